// File: rtl/pipe_mips32_pkg.sv
// Shared opcodes, instruction classes and field helpers for the pipe_mips32 core.
package pipe_mips32_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    // Pipeline bubble: an unassigned opcode, so it decodes to NOP everywhere.
    localparam logic [31:0] BUBBLE_IR = 32'hf800_0000;

    typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP} itype_t;

    function automatic logic [5:0] f_op(input logic [31:0] ir);
        return ir[31:26];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] ir);
        return ir[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] ir);
        return ir[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] ir);
        return ir[15:11];
    endfunction

    function automatic logic [31:0] f_imm(input logic [31:0] ir);
        return {{16{ir[15]}}, ir[15:0]};
    endfunction

    function automatic itype_t decode_type(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
            OP_LW:                                         return LOAD;
            OP_SW:                                         return STORE;
            OP_BNEQZ, OP_BEQZ:                             return BRANCH;
            OP_HLT:                                        return HALT;
            default:                                       return NOP;
        endcase
    endfunction

endpackage

// File: rtl/pipe_mips32_alu.sv
// Combinational ALU; loads and stores reuse the adder for address generation.
module pipe_mips32_alu
    import pipe_mips32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [5:0]  op,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: result = a + b;
            OP_SUB, OP_SUBI:               result = a - b;
            OP_AND:                        result = a & b;
            OP_OR:                         result = a | b;
            OP_SLT, OP_SLTI:               result = {31'b0, $signed(a) < $signed(b)};
            OP_MUL:                        result = a * b;
            default:                       result = '0;
        endcase
    end

endmodule

// File: rtl/pipe_mips32.sv
// Five-stage in-order MIPS32-subset core with EX forwarding, load-use stall,
// EX-resolved branches and HLT draining; register file and unified memory inside.
module pipe_mips32
    import pipe_mips32_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic clk,
    input  logic rst,
    output logic halted
);

    logic [31:0]   Mem [0:MEM_DEPTH-1];
    logic [31:0]   Reg [0:31];
    logic [AW-1:0] PC;
    logic          HALTED;
    logic          TAKEN_BRANCH;

    logic [31:0]   if_id_ir;
    logic [AW-1:0] if_id_npc;
    logic [31:0]   id_ex_ir, id_ex_a, id_ex_b;
    logic [AW-1:0] id_ex_npc;
    itype_t        id_ex_type;
    logic [31:0]   ex_mem_alu, ex_mem_b;
    logic [4:0]    ex_mem_dst;
    logic          ex_mem_we;
    itype_t        ex_mem_type;
    logic [31:0]   mem_wb_val;
    logic [4:0]    mem_wb_dst;
    logic          mem_wb_we;
    itype_t        mem_wb_type;

    // ID: decode and write-through register read
    itype_t     id_type;
    logic [4:0] id_rs, id_rt;
    logic [31:0] id_a, id_b;
    logic       id_uses_rs, id_uses_rt, load_use;

    assign id_type    = decode_type(f_op(if_id_ir));
    assign id_rs      = f_rs(if_id_ir);
    assign id_rt      = f_rt(if_id_ir);
    assign id_a       = (id_rs == 5'd0) ? '0 :
                        (mem_wb_we && mem_wb_dst == id_rs) ? mem_wb_val : Reg[id_rs];
    assign id_b       = (id_rt == 5'd0) ? '0 :
                        (mem_wb_we && mem_wb_dst == id_rt) ? mem_wb_val : Reg[id_rt];
    assign id_uses_rs = id_type inside {RR_ALU, RM_ALU, LOAD, STORE, BRANCH};
    assign id_uses_rt = id_type inside {RR_ALU, STORE};

    // EX: operand forwarding (EX/MEM overrides MEM/WB as the younger producer)
    logic [5:0]    ex_op;
    logic [4:0]    ex_rs, ex_rt, ex_dst;
    logic [31:0]   ex_imm, fwd_a, fwd_b, alu_b, alu_out;
    logic          ex_we, taken;
    logic [AW-1:0] target;

    assign ex_op  = f_op(id_ex_ir);
    assign ex_rs  = f_rs(id_ex_ir);
    assign ex_rt  = f_rt(id_ex_ir);
    assign ex_imm = f_imm(id_ex_ir);

    always_comb begin
        fwd_a = id_ex_a;
        fwd_b = id_ex_b;
        if (mem_wb_we && mem_wb_dst == ex_rs) fwd_a = mem_wb_val;
        if (mem_wb_we && mem_wb_dst == ex_rt) fwd_b = mem_wb_val;
        if (ex_mem_we && ex_mem_type != LOAD && ex_mem_dst == ex_rs) fwd_a = ex_mem_alu;
        if (ex_mem_we && ex_mem_type != LOAD && ex_mem_dst == ex_rt) fwd_b = ex_mem_alu;
    end

    assign alu_b    = (id_ex_type == RR_ALU) ? fwd_b : ex_imm;
    assign ex_dst   = (id_ex_type == RR_ALU) ? f_rd(id_ex_ir) : ex_rt;
    assign ex_we    = (id_ex_type inside {RR_ALU, RM_ALU, LOAD}) && ex_dst != 5'd0;
    assign taken    = id_ex_type == BRANCH && ((ex_op == OP_BEQZ) == (fwd_a == 32'd0));
    assign target   = id_ex_npc + ex_imm[AW-1:0];
    // A load's value only exists after MEM, so its consumer must wait a cycle.
    assign load_use = id_ex_type == LOAD && ex_rt != 5'd0 &&
                      ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));

    pipe_mips32_alu u_alu (
        .a      (fwd_a),
        .b      (alu_b),
        .op     (ex_op),
        .result (alu_out)
    );

    // Fetch stays frozen from the moment HLT decodes until reset.
    logic fetch_stop;
    assign fetch_stop = (id_type == HALT) || id_ex_type == HALT || ex_mem_type == HALT ||
                        mem_wb_type == HALT || HALTED;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            if_id_ir     <= BUBBLE_IR;
            if_id_npc    <= '0;
            id_ex_ir     <= BUBBLE_IR;
            id_ex_a      <= '0;
            id_ex_b      <= '0;
            id_ex_npc    <= '0;
            id_ex_type   <= NOP;
            ex_mem_alu   <= '0;
            ex_mem_b     <= '0;
            ex_mem_dst   <= '0;
            ex_mem_we    <= 1'b0;
            ex_mem_type  <= NOP;
            mem_wb_val   <= '0;
            mem_wb_dst   <= '0;
            mem_wb_we    <= 1'b0;
            mem_wb_type  <= NOP;
        end else begin
            TAKEN_BRANCH <= taken;
            if (mem_wb_type == HALT) HALTED <= 1'b1;

            if (taken) begin
                PC       <= target;
                if_id_ir <= BUBBLE_IR;
            end else if (!load_use) begin
                if (fetch_stop) begin
                    if_id_ir <= BUBBLE_IR;
                end else begin
                    if_id_ir  <= Mem[PC];
                    if_id_npc <= PC + 1'b1;
                    PC        <= PC + 1'b1;
                end
            end

            if (taken || load_use) begin
                id_ex_ir   <= BUBBLE_IR;
                id_ex_type <= NOP;
            end else begin
                id_ex_ir   <= if_id_ir;
                id_ex_type <= id_type;
                id_ex_a    <= id_a;
                id_ex_b    <= id_b;
                id_ex_npc  <= if_id_npc;
            end

            ex_mem_alu  <= alu_out;
            ex_mem_b    <= fwd_b;
            ex_mem_dst  <= ex_dst;
            ex_mem_we   <= ex_we;
            ex_mem_type <= id_ex_type;

            mem_wb_val  <= (ex_mem_type == LOAD) ? Mem[ex_mem_alu[AW-1:0]] : ex_mem_alu;
            mem_wb_dst  <= ex_mem_dst;
            mem_wb_we   <= ex_mem_we;
            mem_wb_type <= ex_mem_type;
        end
    end

    // Storage is not reset; reset bubbles keep both write enables low.
    always_ff @(posedge clk) begin
        if (ex_mem_type == STORE) Mem[ex_mem_alu[AW-1:0]] <= ex_mem_b;
        if (mem_wb_we) Reg[mem_wb_dst] <= mem_wb_val;
    end

    assign halted = HALTED;

endmodule

// File: tb/tb_pipe_mips32.sv
// Bench for pipe_mips32: directed programs plus random programs checked against an ISA-level model.
module tb_pipe_mips32;

    localparam int MD = 1024;
    localparam logic [5:0] O_ADD = 6'b000000, O_SUB = 6'b000001, O_AND = 6'b000010,
                           O_OR = 6'b000011, O_SLT = 6'b000100, O_MUL = 6'b000101,
                           O_LW = 6'b001000, O_SW = 6'b001001, O_ADDI = 6'b001010,
                           O_SUBI = 6'b001011, O_SLTI = 6'b001100, O_BNEQZ = 6'b001101,
                           O_BEQZ = 6'b001110, O_HLT = 6'b111111, O_UND = 6'b111110;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halted;

    pipe_mips32 #(.MEM_DEPTH(MD)) dut (.clk(clk), .rst(rst), .halted(halted));

    always #5 clk = ~clk;

    // scoreboard state
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] img_mem [0:MD-1];
    logic [31:0] img_reg [0:31];
    logic [31:0] m_mem [0:MD-1];
    logic [31:0] m_reg [0:31];
    int m_cycles, m_taken;
    int dut_cycles, dut_pulses;
    int fact_cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] op, input int rs, input int rt, input int rd);
        logic [4:0] s, t, d;
        s = rs[4:0]; t = rt[4:0]; d = rd[4:0];
        return {op, s, t, d, 11'b0};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input int imm);
        logic [4:0] s, t;
        logic [15:0] v;
        s = rs[4:0]; t = rt[4:0]; v = imm[15:0];
        return {op, s, t, v};
    endfunction

    // driver tasks
    task automatic new_image();
        for (int i = 0; i < MD; i++) img_mem[i] = 32'h0;
        for (int i = 0; i < 32; i++) img_reg[i] = i;
    endtask

    task preload();
        for (int i = 0; i < MD; i++) dut.Mem[i] <= img_mem[i];
        for (int i = 0; i < 32; i++) dut.Reg[i] <= img_reg[i];
    endtask

    task automatic run_dut(input int budget);
        rst = 1'b1;
        preload();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dut_cycles = 0;
        dut_pulses = 0;
        while (dut_cycles < budget) begin
            @(posedge clk);
            dut_cycles++;
            @(negedge clk);
            if (dut.TAKEN_BRANCH) dut_pulses++;
            if (halted) break;
        end
    endtask

    // reference model: one instruction per step, timing from the hazard rules
    function automatic void wr(input int r, input logic [31:0] v);
        if (r != 0) m_reg[r] = v;
    endfunction

    task automatic model_run();
        int pc, n, stalls, prev_ld, rs, rt, rd, simm;
        bit done, u_rs, u_rt;
        logic [31:0] ir, a, b, imm, addr;
        logic [5:0] op;
        pc = 0; n = 0; stalls = 0; prev_ld = 0; done = 0; m_taken = 0;
        for (int i = 0; i < MD; i++) m_mem[i] = img_mem[i];
        for (int i = 0; i < 32; i++) m_reg[i] = img_reg[i];
        for (int step = 0; step < 4000 && !done; step++) begin
            ir = m_mem[pc];
            op = ir[31:26];
            rs = int'(ir[25:21]); rt = int'(ir[20:16]); rd = int'(ir[15:11]);
            imm = {{16{ir[15]}}, ir[15:0]};
            simm = int'($signed(ir[15:0]));
            a = (rs == 0) ? 32'h0 : m_reg[rs];
            b = (rt == 0) ? 32'h0 : m_reg[rt];
            addr = a + imm;
            u_rs = op inside {O_ADD, O_SUB, O_AND, O_OR, O_SLT, O_MUL, O_LW, O_SW,
                              O_ADDI, O_SUBI, O_SLTI, O_BNEQZ, O_BEQZ};
            u_rt = op inside {O_ADD, O_SUB, O_AND, O_OR, O_SLT, O_MUL, O_SW};
            if (prev_ld != 0 && ((u_rs && rs == prev_ld) || (u_rt && rt == prev_ld))) stalls++;
            prev_ld = (op == O_LW) ? rt : 0;
            n++;
            pc = (pc + 1) & (MD - 1);
            case (op)
                O_ADD:  wr(rd, a + b);
                O_SUB:  wr(rd, a - b);
                O_AND:  wr(rd, a & b);
                O_OR:   wr(rd, a | b);
                O_SLT:  wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                O_MUL:  wr(rd, a * b);
                O_ADDI: wr(rt, a + imm);
                O_SUBI: wr(rt, a - imm);
                O_SLTI: wr(rt, ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0);
                O_LW:   wr(rt, m_mem[addr[9:0]]);
                O_SW:   m_mem[addr[9:0]] = b;
                O_BEQZ, O_BNEQZ:
                    if ((a == 0) == (op == O_BEQZ)) begin
                        pc = (pc + simm) & (MD - 1);
                        m_taken++;
                    end
                O_HLT:  done = 1;
                default: ;
            endcase
        end
        m_cycles = done ? (n + 4 + stalls + 2 * m_taken) : -1;
    endtask

    task automatic score(input string name);
        exp_q.delete();
        check({name, " halted"}, {31'b0, halted}, 32'd1);
        check({name, " cycles"}, dut_cycles, m_cycles);
        check({name, " branch pulses"}, dut_pulses, m_taken);
        for (int r = 0; r < 32; r++) exp_q.push_back(m_reg[r]);
        for (int a = 96; a < 208; a++) exp_q.push_back(m_mem[a]);
        for (int r = 0; r < 32; r++) check($sformatf("%s R%0d", name, r), dut.Reg[r], exp_q.pop_front());
        for (int a = 96; a < 208; a++) check($sformatf("%s Mem[%0d]", name, a), dut.Mem[a], exp_q.pop_front());
    endtask

    task automatic run_test(input string name);
        model_run();
        run_dut(2000);
        score(name);
    endtask

    task automatic load_fact();
        new_image();
        img_reg[10] = 200;
        img_mem[200] = 7;
        img_mem[0] = i_ins(O_LW, 10, 3, 0);
        img_mem[1] = i_ins(O_ADDI, 0, 2, 1);
        img_mem[2] = r_ins(O_MUL, 2, 3, 2);
        img_mem[3] = i_ins(O_SUBI, 3, 3, 1);
        img_mem[4] = i_ins(O_BNEQZ, 3, 0, -3);
        img_mem[5] = i_ins(O_SW, 10, 2, -2);
        img_mem[6] = i_ins(O_HLT, 0, 0, 0);
    endtask

    task automatic gen_random(input int n);
        int k, rs, rt, rd, lim;
        logic [31:0] w;
        new_image();
        for (int r = 1; r < 32; r++) img_reg[r] = (r % 2 == 1) ? $urandom : $urandom_range(0, 2);
        for (int a = 100; a < 132; a++) img_mem[a] = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0;
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 13);
            rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
            lim = (n - 1 - i < 3) ? n - 1 - i : 3;
            case (k)
                0: w = r_ins(O_ADD, rs, rt, rd);
                1: w = r_ins(O_SUB, rs, rt, rd);
                2: w = r_ins(O_AND, rs, rt, rd);
                3: w = r_ins(O_OR, rs, rt, rd);
                4: w = r_ins(O_SLT, rs, rt, rd);
                5: w = r_ins(O_MUL, rs, rt, rd);
                6: w = i_ins(O_ADDI, rs, rt, $urandom_range(0, 400) - 200);
                7: w = i_ins(O_SUBI, rs, rt, $urandom_range(0, 400) - 200);
                8: w = i_ins(O_SLTI, rs, rt, $urandom_range(0, 400) - 200);
                9: w = i_ins(O_LW, 0, rt, $urandom_range(100, 131));
                10: w = i_ins(O_SW, 0, rt, $urandom_range(100, 131));
                11: w = i_ins(O_BEQZ, rs, 0, $urandom_range(0, lim));
                12: w = i_ins(O_BNEQZ, rs, 0, $urandom_range(0, lim));
                default: w = {O_UND, $urandom_range(0, 1023) * 64'd0 == 0 ? 26'h0_1234 : 26'h0};
            endcase
            img_mem[i] = w;
        end
        img_mem[n] = i_ins(O_HLT, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] snap2, snap3;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset halted", {31'b0, halted}, 32'd0);
        check("reset PC", 32'(dut.PC), 32'd0);
        check("reset taken", {31'b0, dut.TAKEN_BRANCH}, 32'd0);

        // dependent ADDIs separated by ORs
        new_image();
        img_mem[0] = 32'h2801000a; img_mem[1] = 32'h28020014; img_mem[2] = 32'h28030019;
        img_mem[3] = r_ins(O_OR, 7, 7, 7); img_mem[4] = r_ins(O_OR, 7, 7, 7);
        img_mem[5] = 32'h00222000; img_mem[6] = r_ins(O_OR, 7, 7, 7);
        img_mem[7] = 32'h00832800; img_mem[8] = 32'hfc000000;
        run_test("padded");
        check("padded R4", dut.Reg[4], 32'd30);
        check("padded R5", dut.Reg[5], 32'd55);
        check("padded within 20", {31'b0, dut_cycles <= 20}, 32'd1);

        // same program, back to back
        new_image();
        img_mem[0] = 32'h2801000a; img_mem[1] = 32'h28020014; img_mem[2] = 32'h28030019;
        img_mem[3] = 32'h00222000; img_mem[4] = 32'h00832800; img_mem[5] = 32'hfc000000;
        run_test("fwd");
        check("fwd R1", dut.Reg[1], 32'd10);
        check("fwd R5", dut.Reg[5], 32'd55);

        new_image();
        img_mem[0] = i_ins(O_ADDI, 0, 1, 5); img_mem[1] = i_ins(O_ADDI, 1, 1, 1);
        img_mem[2] = r_ins(O_ADD, 1, 1, 2); img_mem[3] = i_ins(O_HLT, 0, 0, 0);
        run_test("chain");
        check("chain R2", dut.Reg[2], 32'd12);

        // load-use: one stall
        new_image();
        img_mem[120] = 85; img_reg[1] = 120;
        img_mem[0] = i_ins(O_LW, 1, 2, 0); img_mem[1] = i_ins(O_ADDI, 2, 2, 10);
        img_mem[2] = i_ins(O_SW, 1, 2, 1); img_mem[3] = i_ins(O_HLT, 0, 0, 0);
        run_test("loaduse");
        check("loaduse Mem121", dut.Mem[121], 32'd95);
        check("loaduse latency", dut_cycles, 32'd9);

        load_fact();
        run_test("fact");
        check("fact Mem198", dut.Mem[198], 32'd5040);
        fact_cycles = m_cycles;

        // ALU edge cases
        new_image();
        img_reg[8] = 32'h0001_0000;
        img_mem[0] = i_ins(O_ADDI, 0, 1, 1);
        img_mem[1] = r_ins(O_SUB, 0, 1, 2);
        img_mem[2] = r_ins(O_SLT, 2, 1, 3);
        img_mem[3] = i_ins(O_ADDI, 0, 4, 5);
        img_mem[4] = i_ins(O_SLTI, 4, 5, -3);
        img_mem[5] = r_ins(O_MUL, 8, 8, 9);
        img_mem[6] = i_ins(O_ADDI, 0, 0, 7);
        img_mem[7] = r_ins(O_ADD, 0, 0, 11);
        img_mem[8] = i_ins(O_UND, 1, 12, 12);
        img_mem[9] = i_ins(O_HLT, 0, 0, 0);
        run_test("alu");
        check("alu sub", dut.Reg[2], 32'hffff_ffff);
        check("alu slt", dut.Reg[3], 32'd1);
        check("alu slti", dut.Reg[5], 32'd0);
        check("alu mul", dut.Reg[9], 32'd0);
        check("alu r0", dut.Reg[11], 32'd0);
        check("alu undef", dut.Reg[12], 32'd12);

        for (int t = 0; t < 10; t++) begin
            gen_random(24);
            run_test($sformatf("rand%0d", t));
        end

        // asynchronous reset in the middle of the factorial loop
        load_fact();
        run_dut(10);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midreset PC", 32'(dut.PC), 32'd0);
        check("midreset halted", {31'b0, halted}, 32'd0);
        snap2 = dut.Reg[2];
        snap3 = dut.Reg[3];
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midreset R2 held", dut.Reg[2], snap2);
        check("midreset R3 held", dut.Reg[3], snap3);
        check("midreset Mem198", dut.Mem[198], 32'd0);
        rst = 1'b0;
        dut_cycles = 0;
        while (dut_cycles < 2000) begin
            @(posedge clk);
            dut_cycles++;
            @(negedge clk);
            if (halted) break;
        end
        check("rerun halted", {31'b0, halted}, 32'd1);
        check("rerun cycles", dut_cycles, fact_cycles);
        check("rerun Mem198", dut.Mem[198], 32'd5040);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("reset clears halted", {31'b0, halted}, 32'd0);
        check("reset clears PC", 32'(dut.PC), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
